// File: rtl/interval_capture_timer.sv
//==============================================================================
// Module   : interval_capture_timer
// Brief    : Measures start-to-stop intervals in clk cycles and holds each
//            capture until the consumer acknowledges it. Optional macro
//            INTERVAL_CAPTURE_SATURATE_EN selects saturating count / overflow.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module interval_capture_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        result_ready,
    output logic [31:0] result_val,
    output logic        result_valid,
    output logic        busy,
    output logic        overflow
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_count;
    logic [31:0] r_result;
    logic [31:0] w_count_inc;
    logic        w_start_accept;
    logic        w_capture;

`ifdef INTERVAL_CAPTURE_SATURATE_EN
    logic [32:0] w_sum;
    logic        w_carry;
    logic        r_overflow;

    // Carry out of the 33-bit sum marks an interval beyond the 32-bit range.
    assign w_sum       = {1'b0, r_count} + 33'd1;
    assign w_carry     = w_sum[32];
    assign w_count_inc = w_carry ? 32'hFFFF_FFFF : w_sum[31:0];
`else
    assign w_count_inc = r_count + 32'd1;
`endif

    // A start is honoured from IDLE, or on the HOLD handshake edge.
    assign w_start_accept = start && ((r_state == c_st_idle) ||
                                      ((r_state == c_st_hold) && result_ready));
    assign w_capture      = (r_state == c_st_count) && stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_count;
                end
            end
            c_st_count: begin
                if (stop) begin
                    w_state_next = c_st_hold;
                end
            end
            c_st_hold: begin
                if (result_ready) begin
                    w_state_next = start ? c_st_count : c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_comb begin
        busy         = (r_state != c_st_idle);
        result_valid = (r_state == c_st_hold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 32'd0;
            r_result <= 32'd0;
        end else begin
            if (w_start_accept) begin
                r_count <= 32'd0;
            end else if ((r_state == c_st_count) && !stop) begin
                r_count <= w_count_inc;
            end
            // The stop edge itself counts, hence count+1 is captured.
            if (w_capture) begin
                r_result <= w_count_inc;
            end
        end
    end

`ifdef INTERVAL_CAPTURE_SATURATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_start_accept) begin
            r_overflow <= 1'b0;
        end else if (w_capture) begin
            r_overflow <= w_carry;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign result_val = r_result;

endmodule

`default_nettype wire

// File: tb/tb_interval_capture_timer.sv
//==============================================================================
// Module   : tb_interval_capture_timer
// Brief    : Self-checking bench for interval_capture_timer against an
//            interval-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_interval_capture_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        result_ready = 1'b0;
    logic [31:0] result_val;
    logic        result_valid;
    logic        busy;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: is a measurement running, is a result waiting,
    // and how many edges have elapsed since the accepted start.
    bit          m_measuring = 1'b0;
    bit          m_holding   = 1'b0;
    longint      m_elapsed   = 0;
    logic [31:0] m_val       = 32'd0;
    bit          m_ovf       = 1'b0;

    interval_capture_timer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .result_ready (result_ready),
        .result_val   (result_val),
        .result_valid (result_valid),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        longint n;
        if (rst) begin
            m_measuring = 1'b0; m_holding = 1'b0; m_elapsed = 0;
            m_val = 32'd0; m_ovf = 1'b0;
        end else if (m_holding) begin
            if (result_ready) begin
                m_holding = 1'b0;
                if (start) begin
                    m_measuring = 1'b1; m_elapsed = 0; m_ovf = 1'b0;
                end
            end
        end else if (m_measuring) begin
            if (stop) begin
                n = m_elapsed + 1;
`ifdef INTERVAL_CAPTURE_SATURATE_EN
                if (n > 64'hFFFF_FFFF) begin
                    m_val = 32'hFFFF_FFFF; m_ovf = 1'b1;
                end else begin
                    m_val = n[31:0]; m_ovf = 1'b0;
                end
`else
                m_val = n[31:0];
`endif
                m_measuring = 1'b0; m_holding = 1'b1;
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end else if (start) begin
            m_measuring = 1'b1; m_elapsed = 0; m_ovf = 1'b0;
        end
    endtask

    function automatic logic [34:0] exp_vec();
        return {m_holding, m_measuring | m_holding, m_ovf, m_val};
    endfunction

    function automatic logic [34:0] got_vec();
        return {result_valid, busy, overflow, result_val};
    endfunction

    // Advance one rising edge; outputs are then examined 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit rd);
        rst = r; start = s; stop = p; result_ready = rd;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1);
        step();
        step();
        n_cmp++;
        if (got_vec() !== 35'd0) begin
            n_fail++;
            $display("FAIL reset cyc%0d: got v/b/o/val=%h required 0", cyc, got_vec());
        end
        drive(0, 0, 0, 0);
        step();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        for (int i = 1; i < 5; i++) begin
            step();
            n_cmp++;
            if (got_vec() !== exp_vec() || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_count cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
        end
        drive(0, 0, 1, 1);
        step();
        n_cmp++;
        if (result_val !== 32'd5 || result_valid !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_capture cyc%0d: got val=%0d valid=%b required val=5 valid=1", cyc, result_val, result_valid);
        end
        drive(0, 0, 0, 1);
        step();
        n_cmp++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_val !== 32'd5 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_idle cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_hold();
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (result_val !== 32'd1 || result_valid !== 1'b1 || busy !== 1'b1 || got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold_stable cyc%0d: got val=%0d valid=%b busy=%b required 1/1/1", cyc, result_val, result_valid, busy);
            end
            drive(0, i[0], ~i[0], 0);
            step();
        end
        drive(0, 0, 0, 1);
        step();
        n_cmp++;
        if (got_vec() !== exp_vec() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        bit dropped = 1'b0;
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        step(); step();
        drive(0, 0, 1, 0);
        step();
        n_cmp++;
        if (result_val !== 32'd3 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_first cyc%0d: got val=%0d required 3", cyc, result_val);
        end
        drive(0, 1, 0, 1);
        step();
        drive(0, 0, 0, 0);
        for (int i = 1; i < 7; i++) begin
            if (busy !== 1'b1) dropped = 1'b1;
            step();
        end
        drive(0, 0, 1, 0);
        step();
        n_cmp++;
        if (result_val !== 32'd7 || result_valid !== 1'b1 || dropped || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_second cyc%0d: got val=%0d busy_dropped=%b required 7 and 0", cyc, result_val, dropped);
        end
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        step(); step(); step();
        drive(1, 0, 0, 1);
        step();
        drive(0, 0, 1, 0);
        step();
        n_cmp++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result_val !== 32'd0 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rst_mid cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
        end
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        n_cmp++;
        if (result_val !== 32'd2 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rst_fresh cyc%0d: got val=%0d required 2", cyc, result_val);
        end
        // Reset while an unconsumed result is held.
        drive(1, 0, 0, 0);
        step();
        n_cmp++;
        if (got_vec() !== 35'd0) begin
            n_fail++;
            $display("FAIL rst_hold cyc%0d: got %h required 0", cyc, got_vec());
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_simul();
        drive(0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step(); step(); step();
        drive(0, 0, 1, 0);
        step();
        n_cmp++;
        if (result_val !== 32'd4 || result_valid !== 1'b1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul cyc%0d: got val=%0d valid=%b required 4/1", cyc, result_val, result_valid);
        end
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        logic [31:0] near [2];
        near[0] = 32'hFFFF_FFFE;
        near[1] = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, k[0]);
            step();
            drive(0, 0, 0, 0);
            step();
            force dut.r_count = near[k];
            m_elapsed = longint'(near[k]);
            drive(0, 0, 1, 0);
            step();
            release dut.r_count;
            drive(0, 0, 0, 0);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL overflow_%0d cyc%0d: got %h required %h", k, cyc, got_vec(), exp_vec());
                end
                step();
            end
        end
        // Handshake with start: overflow must clear on the accepted start.
        drive(0, 1, 0, 1);
        step();
        drive(0, 0, 0, 0);
        n_cmp++;
        if (overflow !== 1'b0 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL overflow_clear cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
        end
        drive(0, 0, 1, 0);
        step();
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 50) == 0, ($urandom % 5) == 0,
                  ($urandom % 6) == 0, ($urandom % 3) == 0);
            step();
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h required %h", cyc, got_vec(), exp_vec());
            end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_simul();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
